instruction_fetch_unit: RTL and testbench

- Fetch stage between the program counter and the decoder. Owns the PC, drives the instruction memory read address, and registers the combinationally returned word into a single output slot. The slot uses a valid/ready handshake toward decode.
- Supports start, stop, end-of-program completion, branch redirect with flush, and back-pressure stalls.

---
 rtl/ifu_pkg.sv | 28 ++
 rtl/ifu_sat_counter.sv | 31 +++
 rtl/instruction_fetch_unit.sv | 153 +++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ifu_pkg
//  Description : Shared types and constants for the instruction fetch unit:
//                FSM state encoding, default bus widths and the widths of the
//                optional saturating performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
package ifu_pkg;

    // Fetch FSM state encoding, explicit 2-bit width
    typedef enum logic [1:0] {
        IFU_IDLE = 2'd0,
        IFU_RUN  = 2'd1,
        IFU_DONE = 2'd2
    } ifu_state_t;

    // Default PC / instruction widths
    localparam int c_IFU_ADDR_W   = 6;
    localparam int c_IFU_DATA_W   = 64;

    // Performance counter widths
    localparam int c_FETCH_CNT_W  = 32;
    localparam int c_STALL_CNT_W  = 32;
    localparam int c_FLUSH_CNT_W  = 16;

endpackage : ifu_pkg
`default_nettype wire

// File: rtl/ifu_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : ifu_sat_counter
//  Description : Up-counter of parameterised width that sticks at all-ones
//                instead of wrapping. Asynchronous active-low reset to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module ifu_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    // Count up on inc, holding once every bit is set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule : ifu_sat_counter
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch_unit
//  Description : Fetch stage. Owns the PC, drives the instruction memory
//                address and captures the combinational read data into a
//                single valid/ready output slot toward decode. Handles start,
//                stop, end-of-program, branch redirect (flush) and stalls.
//                Optional macro IFU_PERF_COUNTERS_EN adds saturating fetch,
//                stall and flush counters as extra outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit
    import ifu_pkg::*;
#(
    parameter int ADDR_W    = c_IFU_ADDR_W,
    parameter int DATA_W    = c_IFU_DATA_W,
    parameter int LAST_ADDR = 63
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] read_address,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              busy,
`ifdef IFU_PERF_COUNTERS_EN
    output logic [c_FETCH_CNT_W-1:0] fetch_count,
    output logic [c_STALL_CNT_W-1:0] stall_count,
    output logic [c_FLUSH_CNT_W-1:0] flush_count,
`endif
    output logic              done
);

    localparam logic [ADDR_W-1:0] c_LAST_PC = ADDR_W'(LAST_ADDR);

    ifu_state_t        r_state;
    ifu_state_t        w_state_next;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_instr;
    logic [ADDR_W-1:0] r_instr_pc;
    logic              r_instr_valid;

    logic w_run;
    logic w_free;
    logic w_branch;
    logic w_fetch;
    logic w_at_last;

    // Branches only count in RUN; a fetch needs RUN, a free slot, and neither
    // a redirect nor a stop in the same cycle.
    assign w_run     = (r_state == IFU_RUN);
    assign w_free    = !r_instr_valid || instr_ready;
    assign w_branch  = w_run && branch_taken;
    assign w_fetch   = w_run && w_free && !branch_taken && !stop;
    assign w_at_last = (r_pc == c_LAST_PC);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IFU_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: start leaves IDLE/DONE, stop or the final fetch leaves RUN
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IFU_IDLE: if (start) w_state_next = IFU_RUN;
            IFU_RUN: begin
                if (stop)                        w_state_next = IFU_IDLE;
                else if (w_fetch && w_at_last)   w_state_next = IFU_DONE;
            end
            IFU_DONE: if (start) w_state_next = IFU_RUN;
            default:  w_state_next = IFU_IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        busy = (r_state == IFU_RUN);
        done = (r_state == IFU_DONE);
    end

    // PC and output slot: redirect beats fetch, fetch beats plain acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= '0;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
        end else begin
            if (w_branch) begin
                r_pc          <= branch_target;
                r_instr_valid <= 1'b0;
            end else if (w_fetch) begin
                r_instr       <= mem_data;
                r_instr_pc    <= r_pc;
                r_instr_valid <= 1'b1;
                if (!w_at_last) begin
                    r_pc <= r_pc + ADDR_W'(1);
                end
            end else begin
                if (r_instr_valid && instr_ready) begin
                    r_instr_valid <= 1'b0;
                end
                if (!w_run && start) begin
                    r_pc <= '0;
                end
            end
        end
    end

    assign read_address = r_pc;
    assign instr        = r_instr;
    assign instr_pc     = r_instr_pc;
    assign instr_valid  = r_instr_valid;

`ifdef IFU_PERF_COUNTERS_EN
    logic w_stall;
    assign w_stall = w_run && r_instr_valid && !instr_ready;

    ifu_sat_counter #(.WIDTH(c_FETCH_CNT_W)) u_fetch_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_fetch),
        .count (fetch_count)
    );

    ifu_sat_counter #(.WIDTH(c_STALL_CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_stall),
        .count (stall_count)
    );

    ifu_sat_counter #(.WIDTH(c_FLUSH_CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_branch),
        .count (flush_count)
    );
`endif

endmodule : instruction_fetch_unit
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_fetch_unit
//  Description : Directed self-checking bench for instruction_fetch_unit.
//                u_dut runs the default configuration (LAST_ADDR=63),
//                u_dut_wrap uses LAST_ADDR=3 for the wrap-around case.
//                Instruction memory models return word i at address i.
//                Counter checks are compiled only with IFU_PERF_COUNTERS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance signals
    logic              rst_n;
    logic              start, stop, branch_taken, instr_ready;
    logic [ADDR_W-1:0] branch_target;
    logic [ADDR_W-1:0] read_address;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid, busy, done;

    // Wrap instance signals
    logic              rst1_n;
    logic              start1, stop1, branch1, ready1;
    logic [ADDR_W-1:0] target1;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] mdata1;
    logic [DATA_W-1:0] instr1;
    logic [ADDR_W-1:0] ipc1;
    logic              ivalid1, busy1, done1;

`ifdef IFU_PERF_COUNTERS_EN
    logic [31:0] fetch_count, stall_count, fetch_count1, stall_count1;
    logic [15:0] flush_count, flush_count1;
`endif

    // Memory models: word i holds value i
    assign mem_data = DATA_W'(read_address);
    assign mdata1   = DATA_W'(raddr1);

    instruction_fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LAST_ADDR(63)) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .stop          (stop),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .read_address  (read_address),
        .mem_data      (mem_data),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .busy          (busy),
`ifdef IFU_PERF_COUNTERS_EN
        .fetch_count   (fetch_count),
        .stall_count   (stall_count),
        .flush_count   (flush_count),
`endif
        .done          (done)
    );

    instruction_fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LAST_ADDR(3)) u_dut_wrap (
        .clk           (clk),
        .rst_n         (rst1_n),
        .start         (start1),
        .stop          (stop1),
        .branch_taken  (branch1),
        .branch_target (target1),
        .read_address  (raddr1),
        .mem_data      (mdata1),
        .instr         (instr1),
        .instr_pc      (ipc1),
        .instr_valid   (ivalid1),
        .instr_ready   (ready1),
        .busy          (busy1),
`ifdef IFU_PERF_COUNTERS_EN
        .fetch_count   (fetch_count1),
        .stall_count   (stall_count1),
        .flush_count   (flush_count1),
`endif
        .done          (done1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; start = 0; stop = 0; branch_taken = 0; branch_target = '0; instr_ready = 1;
        rst1_n = 1'b0; start1 = 0; stop1 = 0; branch1 = 0; target1 = '0; ready1 = 1;
        repeat (2) tick();
        rst_n = 1'b1; rst1_n = 1'b1;
        tick();

        // ---- Reset state ----
        check("rst_valid", 64'(instr_valid), 64'd0);
        check("rst_instr", instr, 64'd0);
        check("rst_ipc",   64'(instr_pc), 64'd0);
        check("rst_pc",    64'(read_address), 64'd0);
        check("rst_busy",  64'(busy), 64'd0);
        check("rst_done",  64'(done), 64'd0);

        // ---- Full program 0..63 ----
        start = 1;
        tick();
        start = 0;
        check("start_busy",  64'(busy), 64'd1);
        check("start_valid", 64'(instr_valid), 64'd0);
        for (int i = 0; i < 64; i++) begin
            tick();
            check("seq_valid", 64'(instr_valid), 64'd1);
            check("seq_ipc",   64'(instr_pc), 64'(i));
            check("seq_instr", instr, 64'(i));
            check("seq_done",  64'(done), (i == 63) ? 64'd1 : 64'd0);
        end
        tick();
        check("end_valid", 64'(instr_valid), 64'd0);
        check("end_done",  64'(done), 64'd1);
        check("end_pc",    64'(read_address), 64'd63);

        // ---- Back-pressure at instr 5 ----
        start = 1;
        tick();
        start = 0;
        check("restart_pc", 64'(read_address), 64'd0);
        for (int i = 0; i <= 5; i++) tick();
        check("bp_pre_instr", instr, 64'd5);
        instr_ready = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_instr", instr, 64'd5);
            check("bp_ipc",   64'(instr_pc), 64'd5);
            check("bp_valid", 64'(instr_valid), 64'd1);
            check("bp_pc",    64'(read_address), 64'd6);
        end
        instr_ready = 1;
        tick();
        check("bp_rel6", instr, 64'd6);
        tick();
        check("bp_rel7", instr, 64'd7);

        // ---- Branch while stalled on instr 10 ----
        tick(); tick(); tick();
        check("br_pre_instr", instr, 64'd10);
        instr_ready = 0;
        tick();
        check("br_stall_instr", instr, 64'd10);
        branch_taken = 1; branch_target = 6'd40;
        tick();
        branch_taken = 0; instr_ready = 1;
        check("br_flush_valid", 64'(instr_valid), 64'd0);
        check("br_pc", 64'(read_address), 64'd40);
`ifdef IFU_PERF_COUNTERS_EN
        check("cnt_flush", 64'(flush_count), 64'd1);
        check("cnt_stall", 64'(stall_count), 64'd5);
        check("cnt_fetch", 64'(fetch_count), 64'd75);
`endif
        for (int i = 40; i <= 42; i++) begin
            tick();
            check("br_valid", 64'(instr_valid), 64'd1);
            check("br_instr", instr, 64'(i));
        end

        // ---- Stop at PC 20, then restart ----
        branch_taken = 1; branch_target = 6'd18;
        tick();
        branch_taken = 0;
        tick();
        check("st_instr18", instr, 64'd18);
        tick();
        check("st_instr19", instr, 64'd19);
        check("st_pc20", 64'(read_address), 64'd20);
        stop = 1; instr_ready = 0;
        tick();
        stop = 0;
        check("st_busy",  64'(busy), 64'd0);
        check("st_valid", 64'(instr_valid), 64'd1);
        check("st_instr", instr, 64'd19);
        check("st_pc",    64'(read_address), 64'd20);
        tick();
        check("st_hold_valid", 64'(instr_valid), 64'd1);
        instr_ready = 1;
        tick();
        check("st_acc_valid", 64'(instr_valid), 64'd0);
        check("st_acc_pc", 64'(read_address), 64'd20);
        start = 1;
        tick();
        start = 0;
        check("rs_busy", 64'(busy), 64'd1);
        check("rs_pc",   64'(read_address), 64'd0);
        tick();
        check("rs_instr", instr, 64'd0);
        check("rs_valid", 64'(instr_valid), 64'd1);
        tick();
        check("rs_instr1", instr, 64'd1);

        // ---- Asynchronous reset between edges ----
        #2;
        rst_n = 0;
        #1;
        check("ar_valid", 64'(instr_valid), 64'd0);
        check("ar_pc",    64'(read_address), 64'd0);
        check("ar_busy",  64'(busy), 64'd0);
        check("ar_instr", instr, 64'd0);
        tick();
        rst_n = 1;
        tick();
        check("ar_after_valid", 64'(instr_valid), 64'd0);
        check("ar_after_busy",  64'(busy), 64'd0);

        // ---- Wrap with LAST_ADDR = 3 ----
        start1 = 1;
        tick();
        start1 = 0;
        branch1 = 1; target1 = 6'd62;
        tick();
        branch1 = 0;
        check("wr_flush_valid", 64'(ivalid1), 64'd0);
        check("wr_pc", 64'(raddr1), 64'd62);
        begin
            int exp_seq [6] = '{62, 63, 0, 1, 2, 3};
            for (int i = 0; i < 6; i++) begin
                tick();
                check("wr_ipc",   64'(ipc1), 64'(exp_seq[i]));
                check("wr_instr", instr1, 64'(exp_seq[i]));
                check("wr_done",  64'(done1), (i == 5) ? 64'd1 : 64'd0);
            end
        end
        tick();
        check("wr_end_valid", 64'(ivalid1), 64'd0);
        branch1 = 1; target1 = 6'd10;
        tick();
        branch1 = 0;
        check("wr_br_ignored_pc",   64'(raddr1), 64'd3);
        check("wr_br_ignored_done", 64'(done1), 64'd1);
`ifdef IFU_PERF_COUNTERS_EN
        check("wr_cnt_flush", 64'(flush_count1), 64'd1);
        check("wr_cnt_fetch", 64'(fetch_count1), 64'd6);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_instruction_fetch_unit
`default_nettype wire
